sram_access_ctrl: RTL and testbench
===================================

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning SRAM word width in bits.
REQ-002 SHALL have parameter SRAM_DEPTH, default 128, meaning the number of SRAM words.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(SRAM_DEPTH), meaning the address width.
REQ-004 SHALL have parameter INITIAL_VALUE, default 0, meaning the word written during clear.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 i_req_valid  input  1  request present.
REQ-009 o_req_ready  output  1  request accepted this cycle when high together with i_req_valid.
REQ-010 i_req_wren  input  1  1 = write, 0 = read.
REQ-011 i_req_addr  input  ADDR_WIDTH  request address.
REQ-012 i_req_wdata  input  DATA_WIDTH  write data.
REQ-013 o_rsp_valid  output  1  read data valid.
REQ-014 i_rsp_ready  input  1  consumer accepts the read data.
REQ-015 o_rsp_rdata  output  DATA_WIDTH  read data.
REQ-016 o_init_busy  output  1  clear sequence in progress.
REQ-017 o_sram_cs, o_sram_wren  output  1 each  SRAM chip select and write enable.
REQ-018 o_sram_addr  output  ADDR_WIDTH; o_sram_din  output  DATA_WIDTH; i_sram_dout  input  DATA_WIDTH (asynchronous read data).

Function
REQ-019 FSM SHALL have two states: CLEAR and RUN.
REQ-020 In RUN, o_req_ready SHALL equal !o_rsp_valid || i_rsp_ready.
REQ-021 Accepted request (valid && ready) SHALL drive o_sram_cs=1, o_sram_wren=i_req_wren, o_sram_addr=i_req_addr, o_sram_din=i_req_wdata combinationally in the same cycle.
REQ-022 An accepted read SHALL register i_sram_dout into o_rsp_rdata and set o_rsp_valid on the next edge (latency 1).
REQ-023 An accepted write SHALL produce no response.
REQ-024 o_rsp_valid and o_rsp_rdata SHALL hold stable while o_rsp_valid && !i_rsp_ready.
REQ-025 o_rsp_valid SHALL clear on the edge after i_rsp_ready unless a new read is accepted in the same cycle, in which case it SHALL stay high with the new data (back-to-back reads, no bubble).
REQ-026 With no accepted request, o_sram_cs and o_sram_wren SHALL be 0.
REQ-027 In CLEAR, o_req_ready SHALL be 0; each cycle SHALL drive o_sram_cs=1, o_sram_wren=1, o_sram_addr=counter, o_sram_din=INITIAL_VALUE.
REQ-028 The clear counter SHALL start at 0, increment by 1 per cycle, and transition to RUN after writing address SRAM_DEPTH-1, taking exactly SRAM_DEPTH cycles.
REQ-029 The clear counter SHALL reset to 0 on entering RUN; it SHALL NOT wrap within CLEAR.
REQ-030 o_init_busy SHALL be 1 exactly while in CLEAR.

Reset
REQ-031 While rst=1 on an edge: o_rsp_valid=0, o_rsp_rdata=0, counter=0, FSM=CLEAR (macro defined) or RUN (macro undefined).
REQ-032 Assertion of rst during CLEAR SHALL restart the clear from address 0; during a pending response it SHALL discard that response.
REQ-033 While rst is high, o_req_ready and o_sram_cs SHALL be 0.

Configuration
REQ-034 Macro SRAM_ACCESS_CTRL_CLEAR_EN defined: the CLEAR state and counter SHALL be compiled in and entered after every reset.
REQ-035 Macro undefined: CLEAR logic SHALL be absent, o_init_busy SHALL be tied 0, and the block SHALL enter RUN on the first edge after reset.

Verification
REQ-036 Macro defined, SRAM_DEPTH=128, release rst -> o_init_busy high for exactly 128 cycles, addresses 0..127 written with INITIAL_VALUE, then o_req_ready=1.
REQ-037 Write addr 5 data 0xDEADBEEF, then read addr 5 with i_rsp_ready=1 -> o_rsp_valid one cycle after the read, o_rsp_rdata=0xDEADBEEF.
REQ-038 Two reads back-to-back (addr 1, 2) with i_rsp_ready=1 -> o_rsp_valid high two consecutive cycles, data in order, o_req_ready never low.
REQ-039 Read with i_rsp_ready=0 for 3 cycles -> o_req_ready=0, rdata stable; raising i_rsp_ready with a new read pending -> new read accepted that cycle.
REQ-040 Assert rst at clear address 60 -> clear restarts at address 0 and lasts a full 128 cycles.
REQ-041 Macro undefined -> o_init_busy=0 and o_req_ready=1 on the first cycle after reset.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// Purpose: single-port SRAM front end; valid/ready requests in, registered read responses out,
//          with an optional post-reset clear pass (enabled by macro SRAM_ACCESS_CTRL_CLEAR_EN).
// Latency: SRAM access in the accept cycle; read data is presented one cycle after acceptance.
// Backpressure: a stalled response (valid && !rsp_ready) blocks new requests; no bubble on
//               back-to-back reads. Requests are refused during reset and during the clear pass.
module sram_access_ctrl #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    SRAM_DEPTH    = 128,
    parameter int                    ADDR_WIDTH    = $clog2(SRAM_DEPTH),
    parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    // request channel
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wren,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    // read response channel
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    // status
    output logic                  o_init_busy,
    // SRAM port (read data is asynchronous)
    output logic                  o_sram_cs,
    output logic                  o_sram_wren,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [DATA_WIDTH-1:0] o_sram_din,
    input  logic [DATA_WIDTH-1:0] i_sram_dout
);

    // High when the block serves requests (always true without the clear pass).
    logic                  in_run;
    logic                  req_ready;
    logic                  req_accept;

    logic                  rsp_valid_q;
    logic                  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;

`ifdef SRAM_ACCESS_CTRL_CLEAR_EN
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SRAM_DEPTH - 1);

    state_e                state_q;
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_d;

    assign in_run      = (state_q == ST_RUN);
    assign o_init_busy = (state_q == ST_CLEAR);

    // Clear sequencer: one word per cycle, leave for RUN after the last address, never wrap.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            if (clr_cnt_q == LAST_ADDR) begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end else begin
            clr_cnt_d = '0;
        end
    end

    // FSM and clear counter registers; every reset restarts the clear pass from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end
`else
    assign in_run      = 1'b1;
    assign o_init_busy = 1'b0;
`endif

    // Request handshake: a pending response that is not being drained blocks new requests.
    always_comb begin
        req_ready  = !rst && in_run && (!rsp_valid_q || i_rsp_ready);
        req_accept = i_req_valid && req_ready;
    end

    // SRAM port: accepted request drives the array in the same cycle; clear pass otherwise.
    // The data bus parks at INITIAL_VALUE when idle so it only toggles on real writes.
    always_comb begin
        o_sram_cs   = 1'b0;
        o_sram_wren = 1'b0;
        o_sram_addr = '0;
        o_sram_din  = INITIAL_VALUE;
        if (req_accept) begin
            o_sram_cs   = 1'b1;
            o_sram_wren = i_req_wren;
            o_sram_addr = i_req_addr;
            o_sram_din  = i_req_wdata;
        end
`ifdef SRAM_ACCESS_CTRL_CLEAR_EN
        else if (!rst && (state_q == ST_CLEAR)) begin
            o_sram_cs   = 1'b1;
            o_sram_wren = 1'b1;
            o_sram_addr = clr_cnt_q;
            o_sram_din  = INITIAL_VALUE;
        end
`endif
    end

    // Response slot: load on an accepted read, drop on drain, otherwise hold.
    // A read accepted in the drain cycle reloads the slot so valid stays high.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        if (req_accept && !i_req_wren) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = i_sram_dout;
        end else if (rsp_valid_q && i_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response registers; reset discards any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign o_req_ready = req_ready;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;

    // The SRAM must never be selected while reset is applied.
    a_no_cs_in_reset: assert property (@(posedge clk) rst |-> !o_sram_cs);

    // A stalled response keeps both valid and data.
    a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
        (o_rsp_valid && !i_rsp_ready) |=> (o_rsp_valid && $stable(o_rsp_rdata)));

    // Requests are refused while the clear pass owns the SRAM.
    a_no_ready_when_busy: assert property (@(posedge clk) o_init_busy |-> !o_req_ready);

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: reset/clear sequencing, directed handshake vectors,
// randomized traffic against a queue-based response model, final SRAM contents check.
// Works for both builds (clear pass enabled or not).
module tb_sram_access_ctrl;

    localparam int          DW    = 32;
    localparam int          DEPTH = 128;
    localparam int          AW    = 7;
    localparam logic [31:0] INIT  = 32'hA5A5_0F0F;
    localparam logic        H     = 1'b1;
    localparam logic        L     = 1'b0;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_wren;
    logic [AW-1:0] i_req_addr;
    logic [DW-1:0] i_req_wdata;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_init_busy;
    logic          o_sram_cs;
    logic          o_sram_wren;
    logic [AW-1:0] o_sram_addr;
    logic [DW-1:0] o_sram_din;
    logic [DW-1:0] i_sram_dout;

    always #5 clk = ~clk;

    sram_access_ctrl #(
        .DATA_WIDTH   (DW),
        .SRAM_DEPTH   (DEPTH),
        .ADDR_WIDTH   (AW),
        .INITIAL_VALUE(INIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_wren (i_req_wren),
        .i_req_addr (i_req_addr),
        .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata),
        .o_init_busy(o_init_busy),
        .o_sram_cs  (o_sram_cs),
        .o_sram_wren(o_sram_wren),
        .o_sram_addr(o_sram_addr),
        .o_sram_din (o_sram_din),
        .i_sram_dout(i_sram_dout)
    );

    // Behavioural SRAM with asynchronous read.
    logic [DW-1:0] sram [DEPTH];
    logic          preload;

    function automatic logic [31:0] pat(input int i);
        return 32'(32'h1000_0000 + i * 32'h0001_0101);
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= pat(i);
        end else if (o_sram_cs && o_sram_wren) begin
            sram[o_sram_addr] <= o_sram_din;
        end
    end
    assign i_sram_dout = sram[o_sram_addr];

    // Reference state: expected SRAM contents and outstanding read responses.
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic rr);
        i_req_valid = v;
        i_req_wren  = w;
        i_req_addr  = a;
        i_req_wdata = d;
        i_rsp_ready = rr;
    endtask

    // Called right after rst is released at a negedge. Follows the clear pass (if built in),
    // optionally re-asserting reset when the pass reaches abort_at.
    task automatic run_clear(input int abort_at);
`ifdef SRAM_ACCESS_CTRL_CLEAR_EN
        int n = 0;
        bit aborted = 0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (!o_init_busy) break;
            chk("clr_rdy",  32'(o_req_ready), 0);
            chk("clr_cs",   32'(o_sram_cs), 1);
            chk("clr_wren", 32'(o_sram_wren), 1);
            chk("clr_addr", 32'(o_sram_addr), n);
            chk("clr_din",  o_sram_din, INIT);
            if (n == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_cs",  32'(o_sram_cs), 0);
                chk("abort_rdy", 32'(o_req_ready), 0);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1;
                break;
            end
            n++;
            @(negedge clk);
        end
        if (!aborted) begin
            chk("clr_len",      n, DEPTH);
            chk("clr_done_rdy", 32'(o_req_ready), 1);
            for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT;
        end
`else
        #1;
        chk("noclr_busy", 32'(o_init_busy), 0);
        chk("noclr_rdy",  32'(o_req_ready), 1);
        if (abort_at > DEPTH) $display("note: abort point unused");
`endif
    endtask

    typedef struct {
        logic          v;
        logic          w;
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic          rr;
        logic          e_rdy;
        logic          e_cs;
        logic          e_vld;
        logic [31:0]   e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic w, input logic [AW-1:0] a,
                                input logic [31:0] d, input logic rr, input logic e_rdy,
                                input logic e_cs, input logic e_vld, input logic [31:0] e_rdata);
        vec_t t;
        t.v = v; t.w = w; t.a = a; t.d = d; t.rr = rr;
        t.e_rdy = e_rdy; t.e_cs = e_cs; t.e_vld = e_vld; t.e_rdata = e_rdata;
        return t;
    endfunction

    vec_t tbl [15];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic          v, w, rr, mrdy;
        logic [AW-1:0] a;
        logic [31:0]   d;

        //        v  w  addr   wdata          rr   rdy cs  vld  rdata
        tbl[0]  = mk(H, H, 7'd5, 32'hDEADBEEF, H,   H, H,  L,  32'h0);
        tbl[1]  = mk(H, L, 7'd5, 32'h0,        H,   H, H,  H,  32'hDEADBEEF);
        tbl[2]  = mk(L, L, 7'd0, 32'h0,        H,   H, L,  L,  32'hDEADBEEF);
        tbl[3]  = mk(H, H, 7'd1, 32'h11111111, H,   H, H,  L,  32'hDEADBEEF);
        tbl[4]  = mk(H, H, 7'd2, 32'h22222222, H,   H, H,  L,  32'hDEADBEEF);
        tbl[5]  = mk(H, L, 7'd1, 32'h0,        H,   H, H,  H,  32'h11111111);
        tbl[6]  = mk(H, L, 7'd2, 32'h0,        H,   H, H,  H,  32'h22222222);
        tbl[7]  = mk(L, L, 7'd0, 32'h0,        H,   H, L,  L,  32'h22222222);
        tbl[8]  = mk(H, L, 7'd5, 32'h0,        L,   H, H,  H,  32'hDEADBEEF);
        tbl[9]  = mk(H, L, 7'd1, 32'h0,        L,   L, L,  H,  32'hDEADBEEF);
        tbl[10] = mk(H, L, 7'd1, 32'h0,        L,   L, L,  H,  32'hDEADBEEF);
        tbl[11] = mk(H, L, 7'd1, 32'h0,        L,   L, L,  H,  32'hDEADBEEF);
        tbl[12] = mk(H, L, 7'd1, 32'h0,        H,   H, H,  H,  32'h11111111);
        tbl[13] = mk(H, H, 7'd5, 32'h0,        H,   H, H,  L,  32'h11111111);
        tbl[14] = mk(L, L, 7'd0, 32'h0,        L,   H, L,  L,  32'h11111111);

        for (int i = 0; i < DEPTH; i++) model_mem[i] = pat(i);

        // Reset with a request pending on the inputs: nothing may reach the SRAM.
        rst = 1'b1;
        preload = 1'b1;
        drive(H, H, 7'd3, 32'h12345678, L);
        @(negedge clk);
        preload = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_rdy",   32'(o_req_ready), 0);
        chk("rst_cs",    32'(o_sram_cs), 0);
        chk("rst_rvld",  32'(o_rsp_valid), 0);
        chk("rst_rdata", o_rsp_rdata, 0);
        @(negedge clk);
        drive(L, L, 7'd0, 32'h0, H);
        rst = 1'b0;
        run_clear(-1);

        // Directed handshake vectors.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rr);
            #1;
            chk($sformatf("vec%0d_rdy", i), 32'(o_req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_cs", i),  32'(o_sram_cs),   32'(tbl[i].e_cs));
            if (tbl[i].e_cs) begin
                chk($sformatf("vec%0d_wren", i), 32'(o_sram_wren), 32'(tbl[i].w));
                chk($sformatf("vec%0d_addr", i), 32'(o_sram_addr), 32'(tbl[i].a));
                chk($sformatf("vec%0d_din", i),  o_sram_din, tbl[i].d);
            end
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rvld", i),  32'(o_rsp_valid), 32'(tbl[i].e_vld));
            chk($sformatf("vec%0d_rdata", i), o_rsp_rdata, tbl[i].e_rdata);
            if (tbl[i].v && tbl[i].w && tbl[i].e_rdy) model_mem[tbl[i].a] = tbl[i].d;
        end

        // Reset while a response is stalled: it must be discarded.
        @(negedge clk);
        drive(H, L, 7'd2, 32'h0, L);
        @(posedge clk);
        #1;
        chk("disc_pre_vld",   32'(o_rsp_valid), 1);
        chk("disc_pre_rdata", o_rsp_rdata, model_mem[2]);
        @(negedge clk);
        rst = 1'b1;
        drive(H, L, 7'd1, 32'h0, L);
        #1;
        chk("disc_rst_rdy", 32'(o_req_ready), 0);
        chk("disc_rst_cs",  32'(o_sram_cs), 0);
        @(posedge clk);
        #1;
        chk("disc_vld",   32'(o_rsp_valid), 0);
        chk("disc_rdata", o_rsp_rdata, 0);
        @(negedge clk);
        drive(L, L, 7'd0, 32'h0, H);
        rst = 1'b0;
        run_clear(-1);

`ifdef SRAM_ACCESS_CTRL_CLEAR_EN
        // Reset in the middle of the clear pass restarts it from address 0.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_clear(60);
        run_clear(-1);
`endif

        // Randomized traffic against the queue model.
        exp_q.delete();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            v  = ($urandom_range(0, 9) < 7);
            w  = ($urandom_range(0, 9) < 4);
            rr = ($urandom_range(0, 9) < 6);
            a  = AW'($urandom_range(0, DEPTH - 1));
            d  = $urandom;
            drive(v, w, a, d, rr);
            #1;
            mrdy = (exp_q.size() == 0) || rr;
            chk("rnd_rdy",  32'(o_req_ready), 32'(mrdy));
            chk("rnd_rvld", 32'(o_rsp_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) chk("rnd_rdata", o_rsp_rdata, exp_q[0]);
            chk("rnd_cs", 32'(o_sram_cs), 32'(v && mrdy));
            if (v && mrdy) begin
                chk("rnd_wren", 32'(o_sram_wren), 32'(w));
                chk("rnd_addr", 32'(o_sram_addr), 32'(a));
                if (w) chk("rnd_din", o_sram_din, d);
            end
            if ((exp_q.size() != 0) && rr) void'(exp_q.pop_front());
            if (v && mrdy) begin
                if (w) model_mem[a] = d;
                else   exp_q.push_back(model_mem[a]);
            end
        end

        // Let the last write land, then compare the whole array.
        @(negedge clk);
        drive(L, L, 7'd0, 32'h0, H);
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) chk($sformatf("mem%0d", i), sram[i], model_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
